// File: rtl/regfile_sb.sv
// regfile_sb: general-purpose register file with scoreboard for the decode stage.
//   NUM_RD combinational read ports with write-to-read bypass, one write port,
//   one busy bit per register for RAW hazard detection, and a post-reset clear
//   sequencer that zeroes every register before ready_o rises.
//
// Ports
//   clk_i        clock, all state changes on the rising edge
//   rst_i        asynchronous active-high reset
//   ready_o      clear sequence done, block accepts traffic
//   we_i         write enable (writeback)
//   waddr_i      write address
//   wdata_i      write data
//   iss_valid_i  issue request, mark iss_addr_i as pending
//   iss_addr_i   destination register of the issuing instruction
//   iss_stall_o  issue refused this cycle; requester holds and retries
//   flush_i      clear all busy bits
//   re_i         read enable, one bit per port
//   raddr_i      read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata_o      read data, port i at [i*DATA_W +: DATA_W]
//   rbusy_o      port i register has a pending producer
//
// state | meaning
// ------+-------------------------------------------------------------
// INIT  | clearing regs[clr_cnt], one register per cycle; traffic ignored
// RUN   | normal operation until the next reset

module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  output logic                       ready_o,
  input  logic                       we_i,
  input  logic [ADDR_W-1:0]          waddr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       iss_valid_i,
  input  logic [ADDR_W-1:0]          iss_addr_i,
  output logic                       iss_stall_o,
  input  logic                       flush_i,
  input  logic [NUM_RD-1:0]          re_i,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr_i,
  output logic [NUM_RD*DATA_W-1:0]   rdata_o,
  output logic [NUM_RD-1:0]          rbusy_o
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_MAX = '1;
  localparam logic [ADDR_W-1:0] CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic                ready_q;
  logic [NREG-1:0]     busy_q;
  logic [NREG-1:0]     busy_d;
  logic [DATA_W-1:0]   regs_q [NREG];

  logic run;
  logic wr_en;
  logic iss_acc;

  assign run     = (state_q == S_RUN);
  assign ready_o = ready_q;
  assign wr_en   = run & we_i & (waddr_i != ADDR_ZERO);

  // A same-cycle write to the pending register releases the stall so the
  // requester can re-issue immediately; a flush always releases it.
  assign iss_stall_o = run & iss_valid_i & busy_q[iss_addr_i]
                     & ~(we_i & (waddr_i == iss_addr_i)) & ~flush_i;
  assign iss_acc     = run & iss_valid_i & ~iss_stall_o;

  // Order matters: write clears, then flush wipes everything, otherwise an
  // accepted issue sets (new producer wins over the retiring write).
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[waddr_i] = 1'b0;
    end
    if (flush_i) begin
      busy_d = '0;
    end else if (iss_acc && (iss_addr_i != ADDR_ZERO)) begin
      busy_d[iss_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_INIT;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          if (clr_cnt_q == CNT_MAX) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + CNT_ONE;
          end
        end
        S_RUN: begin
          busy_q <= busy_d;
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  // Storage needs no reset: the INIT sweep zeroes it and reads are gated
  // to zero until the sweep completes.
  always_ff @(posedge clk_i) begin
    if (state_q == S_INIT) begin
      regs_q[clr_cnt_q] <= '0;
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    ra      = '0;
    rdata_o = '0;
    rbusy_o = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = raddr_i[i*ADDR_W +: ADDR_W];
      if (run && re_i[i] && (ra != ADDR_ZERO)) begin
        if (we_i && (waddr_i == ra)) begin
          rdata_o[i*DATA_W +: DATA_W] = wdata_i;
        end else begin
          rdata_o[i*DATA_W +: DATA_W] = regs_q[ra];
          rbusy_o[i]                  = busy_q[ra];
        end
      end
    end
  end

endmodule
